// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//   Decoupled instruction-fetch stage. A small fetch engine keeps one request
//   outstanding to instruction memory and fills a DEPTH-entry prefetch queue
//   of {pc, insn}. The IF/ID output register is loaded from the queue head.
//   If an ack arrives while the queue is empty and the stage is not stalled,
//   the response goes straight to the output register on that edge. The
//   stage presents the usual IF semantics to ID: branch delay slot, stall
//   and flush.
//
// Optional feature: define IF_BUBBLE_CNT_EN to add if_bubble_cnt_o, a
//   saturating count of cycles in which a bubble (if_en_o=0) is loaded into
//   ID while the stage is neither stalled nor flushed.
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous reset, active low
//   imem_req_o     fetch request, held high until imem_ack_i
//   imem_addr_o    fetch address, stable while imem_req_o=1
//   imem_ack_i     response strobe, imem_rdata_i valid in this cycle
//   imem_rdata_i   fetched instruction
//   stall_i        hold the IF/ID outputs
//   flush_i        redirect to new_pc_i (beats stall_i and br_taken_i)
//   new_pc_i       flush target
//   br_taken_i     branch in ID taken
//   br_addr_i      branch target
//   if_pc_o        PC of if_insn_o
//   if_insn_o      instruction to ID (NOP_INSN when not valid)
//   if_en_o        if_insn_o valid
//   if_bubble_cnt_o  (IF_BUBBLE_CNT_EN only) bubble counter
// ---------------------------------------------------------------------------
module if_fetch_queue #(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0,
    parameter logic [DATA_W-1:0]    NOP_INSN = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_addr_i,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [DATA_W-1:0] if_insn_o,
    output logic              if_en_o
`ifdef IF_BUBBLE_CNT_EN
    ,
    output logic [31:0]       if_bubble_cnt_o
`endif
);

    localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic                br_pend_q, br_pend_d;
    logic [ADDR_W-1:0]   br_tgt_q, br_tgt_d;

    logic [ADDR_W-1:0]   q_pc_q   [DEPTH];
    logic [DATA_W-1:0]   q_insn_q [DEPTH];
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   insn_q, insn_d;
    logic                en_q, en_d;

    logic q_empty, ack, br_now, br_pop, br_hold, redirect;
    logic acc, bypass, push, pop, pend_now, load_req;
    logic [ADDR_W-1:0] tgt_now;

    // ---- event decode ------------------------------------------------------
    always_comb begin
        q_empty  = (cnt_q == '0);
        ack      = imem_ack_i && (state_q != S_IDLE);
        br_now   = br_taken_i && !stall_i && !flush_i;
        // Delay slot already queued: it goes out now, the rest is wrong-path.
        br_pop   = br_now && !q_empty;
        // Delay slot not fetched yet: remember the target until it arrives.
        br_hold  = br_now && q_empty;
        redirect = flush_i || br_pop;
        acc      = ack && (state_q == S_REQ) && !redirect;
        bypass   = acc && q_empty && !stall_i;
        push     = acc && !bypass;
        pop      = !stall_i && !flush_i && !q_empty;
        pend_now = br_pend_q || br_hold;
        tgt_now  = br_hold ? br_addr_i : br_tgt_q;
    end

    // ---- fetch PC, pending branch, queue pointers --------------------------
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        br_pend_d  = br_pend_q;
        br_tgt_d   = br_hold ? br_addr_i : br_tgt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;

        if (flush_i) begin
            fetch_pc_d = new_pc_i;
        end else if (br_pop) begin
            fetch_pc_d = br_addr_i;
        end else if (acc) begin
            // The accepted response is the delay slot when a branch waits.
            fetch_pc_d = pend_now ? tgt_now : fetch_pc_q + ADDR_W'(4);
        end

        if (redirect || acc) begin
            br_pend_d = 1'b0;
        end else if (br_hold) begin
            br_pend_d = 1'b1;
        end

        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + ONE_C;
                2'b01:   cnt_d = cnt_q - ONE_C;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // ---- memory FSM: next state --------------------------------------------
    always_comb begin
        state_d  = state_q;
        load_req = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cnt_q < DEPTH_C) begin
                    state_d  = S_REQ;
                    load_req = 1'b1;
                end
            end
            S_REQ: begin
                if (ack) begin
                    // A redirected response empties the queue, so there is room.
                    if (redirect || (cnt_q + ONE_C < DEPTH_C)) begin
                        state_d  = S_REQ;
                        load_req = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (redirect) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (ack) begin
                    state_d  = S_REQ;
                    load_req = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        addr_d = load_req ? fetch_pc_d : addr_q;
    end

    // ---- memory FSM: outputs -----------------------------------------------
    always_comb begin
        imem_req_o  = (state_q != S_IDLE);
        imem_addr_o = addr_q;
    end

    // ---- IF/ID output register next value ----------------------------------
    always_comb begin
        pc_d   = pc_q;
        insn_d = insn_q;
        en_d   = en_q;
        if (flush_i) begin
            pc_d   = new_pc_i;
            insn_d = NOP_INSN;
            en_d   = 1'b0;
        end else if (!stall_i) begin
            if (!q_empty) begin
                pc_d   = q_pc_q[rd_ptr_q];
                insn_d = q_insn_q[rd_ptr_q];
                en_d   = 1'b1;
            end else if (bypass) begin
                pc_d   = addr_q;
                insn_d = imem_rdata_i;
                en_d   = 1'b1;
            end else begin
                insn_d = NOP_INSN;
                en_d   = 1'b0;
            end
        end
    end

    // ---- state registers ---------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            br_pend_q  <= 1'b0;
            br_tgt_q   <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            pc_q       <= RESET_PC;
            insn_q     <= NOP_INSN;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            br_pend_q  <= br_pend_d;
            br_tgt_q   <= br_tgt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            insn_q     <= insn_d;
            en_q       <= en_d;
        end
    end

    // Queue storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_pc_q[wr_ptr_q]   <= addr_q;
            q_insn_q[wr_ptr_q] <= imem_rdata_i;
        end
    end

    assign if_pc_o   = pc_q;
    assign if_insn_o = insn_q;
    assign if_en_o   = en_q;

`ifdef IF_BUBBLE_CNT_EN
    logic [31:0] bub_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bub_q <= '0;
        end else if (!stall_i && !flush_i && !en_d && (bub_q != 32'hFFFF_FFFF)) begin
            bub_q <= bub_q + 32'd1;
        end
    end

    assign if_bubble_cnt_o = bub_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: bench-side instruction memory with configurable
// latency, and a reference model of the instruction stream seen by ID
// (program order, delay slot, flush target, stall hold).
module tb_if_fetch_queue;

    logic        clk_i, rst_ni;
    logic        imem_req_o, imem_ack_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic        stall_i, flush_i, br_taken_i;
    logic [31:0] new_pc_i, br_addr_i;
    logic [31:0] if_pc_o, if_insn_o;
    logic        if_en_o;
`ifdef IF_BUBBLE_CNT_EN
    logic [31:0] if_bubble_cnt_o;
`endif

    if_fetch_queue dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .new_pc_i     (new_pc_i),
        .br_taken_i   (br_taken_i),
        .br_addr_i    (br_addr_i),
        .if_pc_o      (if_pc_o),
        .if_insn_o    (if_insn_o),
        .if_en_o      (if_en_o)
`ifdef IF_BUBBLE_CNT_EN
        ,
        .if_bubble_cnt_o (if_bubble_cnt_o)
`endif
    );

    always begin
        clk_i = 1'b0; #5;
        clk_i = 1'b1; #5;
    end

    int n_cmp, n_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // ---- memory model ----
    int          mem_lat;      // <0: random 0..4 per request
    bit          mbusy;
    int          mleft;
    logic [31:0] maddr;
    int          n_acks;
    logic [31:0] req_log[$];

    task automatic mem_step();
        if (!rst_ni) begin
            mbusy = 0; imem_ack_i = 1'b0; n_acks = 0; req_log.delete();
        end else begin
            if (imem_ack_i) begin
                imem_ack_i = 1'b0; mbusy = 0; n_acks++;
            end
            if (imem_req_o) begin
                if (!mbusy) begin
                    mbusy = 1; maddr = imem_addr_o; req_log.push_back(imem_addr_o);
                    mleft = (mem_lat < 0) ? int'($urandom_range(0, 4)) : mem_lat;
                end else begin
                    chk("addr_stable", imem_addr_o, maddr);
                end
                if (mleft == 0) begin
                    imem_ack_i = 1'b1; imem_rdata_i = mem_word(maddr);
                end else begin
                    mleft--;
                end
            end else if (mbusy) begin
                chk("req_held", 32'(imem_req_o), 32'd1);
                mbusy = 0;
            end
        end
    endtask

    // ---- stream reference model ----
    logic        s_stall, s_flush, s_br, p_en;
    logic [31:0] s_new, s_bra, p_pc, p_insn;
    logic [31:0] exp_pc, br_tgt;
    bit          pend, ds_now;
    int          n_valid, n_bub;

    task automatic chk_step();
        if (!rst_ni) begin
            exp_pc = 32'h0; pend = 0; ds_now = 0; n_valid = 0; n_bub = 0;
        end else begin
`ifdef IF_BUBBLE_CNT_EN
            if (!s_stall && !s_flush && !if_en_o) n_bub++;
            chk("bubble_cnt", if_bubble_cnt_o, 32'(n_bub));
`endif
            if (s_flush) begin
                chk("flush_en", 32'(if_en_o), 32'd0);
                chk("flush_insn", if_insn_o, 32'h0);
                chk("flush_pc", if_pc_o, s_new);
                exp_pc = s_new; pend = 0; ds_now = 0;
            end else if (s_stall) begin
                chk("stall_en", 32'(if_en_o), 32'(p_en));
                chk("stall_pc", if_pc_o, p_pc);
                chk("stall_insn", if_insn_o, p_insn);
            end else begin
                if (s_br) begin
                    pend = 1; br_tgt = s_bra;
                end
                if (if_en_o) begin
                    n_valid++;
                    chk("stream_pc", if_pc_o, exp_pc);
                    chk("stream_insn", if_insn_o, mem_word(if_pc_o));
                    ds_now = pend;
                    if (pend) begin exp_pc = br_tgt; pend = 0; end
                    else exp_pc = exp_pc + 32'd4;
                end else begin
                    chk("bubble_insn", if_insn_o, 32'h0);
                    chk("bubble_pc", if_pc_o, p_pc);
                end
            end
        end
    endtask

    task automatic tick();
        s_stall = stall_i; s_flush = flush_i; s_br = br_taken_i;
        s_new = new_pc_i; s_bra = br_addr_i;
        p_pc = if_pc_o; p_insn = if_insn_o; p_en = if_en_o;
        @(negedge clk_i);
        chk_step();
        mem_step();
        #1;
    endtask

    task automatic do_reset(input logic stall_v);
        rst_ni = 1'b0; stall_i = stall_v; flush_i = 1'b0; br_taken_i = 1'b0;
        tick(); tick();
        chk("rst_pc", if_pc_o, 32'h0);
        chk("rst_insn", if_insn_o, 32'h0);
        chk("rst_en", 32'(if_en_o), 32'd0);
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_addr", imem_addr_o, 32'h0);
        rst_ni = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] exp, input int maxc);
        int i = 0;
        while (!if_en_o && i < maxc) begin tick(); i++; end
        if (!if_en_o) chk({tag, "_timeout"}, 32'(if_en_o), 32'd1);
        else chk(tag, if_pc_o, exp);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_ni = 1'b0; stall_i = 1'b0; flush_i = 1'b0; br_taken_i = 1'b0;
        new_pc_i = '0; br_addr_i = '0; imem_ack_i = 1'b0; imem_rdata_i = '0;
        mem_lat = 1;
        #1;

        // sequential fetch, ack one cycle after each request
        mem_lat = 1;
        do_reset(1'b0);
        wait_valid("t1_first", 32'h0, 20); tick();
        wait_valid("t1_second", 32'h4, 20); tick();
        wait_valid("t1_third", 32'h8, 20);
        for (int k = 0; k < 3; k++)
            chk("t1_addr", (k < req_log.size()) ? req_log[k] : 32'hDEAD_BEEF, 32'(4 * k));

        // stalled stage fills exactly DEPTH entries, then drains without gap
        mem_lat = 5;
        do_reset(1'b1);
        repeat (40) tick();
        chk("t2_acks", 32'(n_acks), 32'd4);
        chk("t2_req_low", 32'(imem_req_o), 32'd0);
        chk("t2_frozen_en", 32'(if_en_o), 32'd0);
        stall_i = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("t2_drain_en", 32'(if_en_o), 32'd1);
            chk("t2_drain_pc", if_pc_o, 32'(4 * k));
            tick();
        end

        // branch with delay slot already queued; wrong-path entries discarded
        mem_lat = 0;
        do_reset(1'b0);
        for (int i = 0; i < 40; i++) begin
            if (if_en_o && if_pc_o == 32'h10) break;
            tick();
        end
        chk("t3_reach", if_pc_o, 32'h10);
        stall_i = 1'b1;
        repeat (6) tick();
        stall_i = 1'b0; br_taken_i = 1'b1; br_addr_i = 32'h100;
        tick();
        br_taken_i = 1'b0;
        chk("t3_ds_en", 32'(if_en_o), 32'd1);
        chk("t3_ds_pc", if_pc_o, 32'h14);
        tick();
        wait_valid("t3_target", 32'h100, 20);

        // flush during stall with a request outstanding
        mem_lat = 6;
        do_reset(1'b1);
        repeat (3) tick();
        flush_i = 1'b1; new_pc_i = 32'h80;
        tick();
        flush_i = 1'b0;
        chk("t4_en", 32'(if_en_o), 32'd0);
        chk("t4_insn", if_insn_o, 32'h0);
        chk("t4_pc", if_pc_o, 32'h80);
        chk("t4_req_kept", 32'(imem_req_o), 32'd1);
        stall_i = 1'b0;
        wait_valid("t4_first", 32'h80, 40);

        // branch with empty queue, delay-slot request in flight
        mem_lat = 3;
        do_reset(1'b0);
        for (int i = 0; i < 100; i++) begin
            if (if_en_o && if_pc_o == 32'h20) break;
            tick();
        end
        chk("t5_reach", if_pc_o, 32'h20);
        br_taken_i = 1'b1; br_addr_i = 32'h200;
        tick();
        br_taken_i = 1'b0;
        wait_valid("t5_delay_slot", 32'h24, 20);
        chk("t5_next_addr", imem_addr_o, 32'h200);
        tick();
        wait_valid("t5_target", 32'h200, 30);

        // randomized traffic, including PC wrap near the top of memory
        mem_lat = -1;
        do_reset(1'b0);
        for (int c = 0; c < 2000; c++) begin
            stall_i    = ($urandom_range(0, 3) == 0);
            flush_i    = ($urandom_range(0, 59) == 0);
            new_pc_i   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0
                         : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            br_taken_i = if_en_o && !pend && !ds_now && ($urandom_range(0, 4) == 0);
            br_addr_i  = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
            tick();
        end
        stall_i = 1'b0; flush_i = 1'b0; br_taken_i = 1'b0;
        chk("rand_progress", 32'(n_valid > 150), 32'd1);

        // reset that may abandon an outstanding request
        do_reset(1'b0);
        wait_valid("post_rst_first", 32'h0, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
